// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave register front-end
package spi_pkg;

    // Slave frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    // Byte driven on MISO when the host has nothing queued at a byte boundary
    localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

    // Mode 0: SCLK idles low, data launched on the falling edge, MSB first
    localparam logic       SPI_CPOL    = 1'b0;
    localparam logic [2:0] SPI_MSB_IDX = 3'd7;

endpackage

// File: rtl/spi_slave_rf_if.sv
// rtl/spi_slave_rf_if.sv - SPI pins plus host byte interface of the SPI slave
interface spi_slave_rf_if;
    logic       sclk;
    logic       csn;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       tx_pending;
    logic       tx_underrun;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_start;
    logic       frame_end;
    logic       busy;

    // View from inside the slave
    modport slave (
        input  sclk, csn, mosi, tx_byte, tx_load,
        output miso, miso_oe, tx_pending, tx_underrun,
        output rx_byte, rx_valid, frame_start, frame_end, busy
    );

    // View from the SPI master and host side
    modport master (
        output sclk, csn, mosi, tx_byte, tx_load,
        input  miso, miso_oe, tx_pending, tx_underrun,
        input  rx_byte, rx_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage input synchronizer with rise/fall pulses
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at bit 0; the top bit is the oldest, settled sample
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // Edges come from the last two stages so both samples are already settled
    assign q    = sync_q[STAGES-1];
    assign rise =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall = ~sync_q[STAGES-2] &  sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rf.sv
// rtl/spi_slave_rf.sv - oversampled Mode 0 SPI slave with tx holding register
module spi_slave_rf
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_rf_if.slave  bus
);

    logic sclk_lvl_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic csn_sync;
    logic csn_rise;
    logic csn_fall;
    logic mosi_sync;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    // CSN resets low so a frame already in progress at reset release never
    // produces a falling edge; the slave waits for the next real CSN fall.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sclk),
        .q    (sclk_lvl_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_csn (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.csn),
        .q    (csn_sync),
        .rise (csn_rise),
        .fall (csn_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.mosi),
        .q    (mosi_sync),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    spi_state_e state_q, state_d;
    logic [7:0] sh_tx_q, sh_tx_d;
    logic [7:0] sh_rx_q, sh_rx_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_done_q, byte_done_d;
    logic       miso_q, miso_d;
    logic       miso_oe_q, miso_oe_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_end_q, frame_end_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic [7:0] hold_q, hold_d;
    logic       tx_pending_q, tx_pending_d;
    logic       busy_q, busy_d;

    logic       reload;
    logic       consume;
    logic [7:0] reload_byte;

    // The next outgoing byte: the host's held byte if any, otherwise the filler
    assign reload_byte = tx_pending_q ? hold_q : IDLE_BYTE;

    // Frame sequencer, shift datapath and tx holding register next-state logic
    always_comb begin
        state_d       = state_q;
        sh_tx_d       = sh_tx_q;
        sh_rx_d       = sh_rx_q;
        bit_cnt_d     = bit_cnt_q;
        byte_done_d   = byte_done_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        rx_byte_d     = rx_byte_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        tx_underrun_d = 1'b0;
        hold_d        = hold_q;
        tx_pending_d  = tx_pending_q;
        busy_d        = busy_q;
        reload        = 1'b0;

        if (state_q != ST_IDLE && csn_rise) begin
            // CSN release wins over any coincident SCLK edge; partial bytes are dropped
            frame_end_d = 1'b1;
            miso_oe_d   = 1'b0;
            miso_d      = 1'b0;
            bit_cnt_d   = SPI_MSB_IDX;
            byte_done_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_oe_d = 1'b0;
                    if (csn_fall) begin
                        frame_start_d = 1'b1;
                        busy_d        = 1'b1;
                        state_d       = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    reload    = 1'b1;
                    miso_oe_d = 1'b1;
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise && !csn_sync) begin
                        sh_rx_d = {sh_rx_q[6:0], mosi_sync};
                        if (bit_cnt_q == 3'd0) begin
                            rx_byte_d   = {sh_rx_q[6:0], mosi_sync};
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (sclk_fall && !csn_sync) begin
                        if (byte_done_q) begin
                            reload = 1'b1;
                        end else begin
                            miso_d = sh_tx_q[bit_cnt_q];
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Byte boundary: fetch the next outgoing byte and present its MSB
        if (reload) begin
            sh_tx_d       = reload_byte;
            miso_d        = reload_byte[7];
            bit_cnt_d     = SPI_MSB_IDX;
            byte_done_d   = 1'b0;
            tx_underrun_d = ~tx_pending_q;
        end

        // A load landing on the consume cycle refills the register right away
        consume = reload & tx_pending_q;
        if (bus.tx_load && (!tx_pending_q || consume)) begin
            hold_d       = bus.tx_byte;
            tx_pending_d = 1'b1;
        end else if (consume) begin
            tx_pending_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sh_tx_q       <= 8'h00;
            sh_rx_q       <= 8'h00;
            bit_cnt_q     <= SPI_MSB_IDX;
            byte_done_q   <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_byte_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
            hold_q        <= 8'h00;
            tx_pending_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_tx_q       <= sh_tx_d;
            sh_rx_q       <= sh_rx_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_done_q   <= byte_done_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            tx_underrun_q <= tx_underrun_d;
            hold_q        <= hold_d;
            tx_pending_q  <= tx_pending_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.miso_oe     = miso_oe_q;
    assign bus.rx_byte     = rx_byte_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.tx_pending  = tx_pending_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_rf.sv
// tb/tb_spi_slave_rf.sv - scoreboard bench for spi_slave_rf driven by a bit-banged SPI master
module tb_spi_slave_rf;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_slave_rf_if bus ();

    spi_slave_rf #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    bit         m_pending = 1'b0;
    logic [7:0] m_hold    = 8'h00;
    int m_underruns = 0, m_starts = 0, m_ends = 0;
    int s_underruns = 0, s_starts = 0, s_ends = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the slave presents a received byte
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            if (exp_rx.size() == 0) chk("rx_unexpected", {24'd0, bus.rx_byte}, 32'hFFFF_FFFF);
            else                    chk("rx_byte", {24'd0, bus.rx_byte}, {24'd0, exp_rx.pop_front()});
        end
        if (bus.tx_underrun) s_underruns++;
        if (bus.frame_start) s_starts++;
        if (bus.frame_end)   s_ends++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Host writes the holding register; only an empty register accepts it
    task automatic host_load(input logic [7:0] b);
        bus.tx_byte = b;
        bus.tx_load = 1'b1;
        step(1);
        bus.tx_load = 1'b0;
        if (!m_pending) begin
            m_hold    = b;
            m_pending = 1'b1;
        end
    endtask

    // Byte boundary in the slave: the held byte goes out, or the filler with an underrun
    function automatic void model_boundary();
        if (m_pending) begin
            exp_tx.push_back(m_hold);
            m_pending = 1'b0;
        end else begin
            exp_tx.push_back(8'hFF);
            m_underruns++;
        end
    endfunction

    task automatic frame_begin();
        bus.csn = 1'b0;
        m_starts++;
        model_boundary();
        step(HALF);
    endtask

    // One Mode 0 bit; on the frame's last bit SCLK falls together with CSN rising
    task automatic spi_bit(input logic b, input bit end_frame, output logic r);
        bus.mosi = b;
        step(HALF);
        r = bus.miso;
        bus.sclk = 1'b1;
        step(HALF);
        bus.sclk = 1'b0;
        if (end_frame) bus.csn = 1'b1;
    endtask

    task automatic spi_byte(input logic [7:0] mo, input bit last, input bit do_load, input logic [7:0] ld);
        logic [7:0] mi;
        logic r;
        mi = 8'h00;
        exp_rx.push_back(mo);
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mo[i], last && (i == 0), r);
            mi[i] = r;
            if (i == 4 && do_load) host_load(ld);
        end
        if (last) m_ends++;
        else      model_boundary();
        chk("miso_byte", {24'd0, mi}, {24'd0, exp_tx.pop_front()});
    endtask

    task automatic frame_finish();
        step(3 * HALF);
        chk("frame_start_cnt", s_starts, m_starts);
        chk("frame_end_cnt", s_ends, m_ends);
        chk("underrun_cnt", s_underruns, m_underruns);
        chk("tx_pending", {31'd0, bus.tx_pending}, {31'd0, m_pending});
        chk("rx_drained", exp_rx.size(), 0);
        chk("miso_oe_idle", {31'd0, bus.miso_oe}, 0);
        chk("busy_idle", {31'd0, bus.busy}, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"},       {31'd0, bus.miso}, 0);
        chk({tag, "_miso_oe"},    {31'd0, bus.miso_oe}, 0);
        chk({tag, "_rx_byte"},    {24'd0, bus.rx_byte}, 0);
        chk({tag, "_rx_valid"},   {31'd0, bus.rx_valid}, 0);
        chk({tag, "_tx_pending"}, {31'd0, bus.tx_pending}, 0);
        chk({tag, "_busy"},       {31'd0, bus.busy}, 0);
        chk({tag, "_pulses"},     {29'd0, bus.frame_start, bus.frame_end, bus.tx_underrun}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic r;
        bit   seen;
        int   nb;
        bus.csn = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        bus.tx_load = 1'b0; bus.tx_byte = 8'h00;
        rst = 1'b1;
        step(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        step(5);

        // Single byte
        host_load(8'hA5);
        chk("tx_pending_loaded", {31'd0, bus.tx_pending}, 1);
        frame_begin();
        spi_byte(8'h3C, 1'b1, 1'b0, 8'h00);
        frame_finish();

        // Multi-byte frame, second tx byte supplied mid-frame, third underruns
        host_load(8'h10);
        frame_begin();
        spi_byte(8'h01, 1'b0, 1'b1, 8'h20);
        spi_byte(8'h02, 1'b0, 1'b0, 8'h00);
        spi_byte(8'h03, 1'b1, 1'b0, 8'h00);
        frame_finish();

        // Abort after five rising edges
        frame_begin();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, i == 4, r);
        m_ends++;
        void'(exp_tx.pop_front());
        frame_finish();
        frame_begin();
        spi_byte(8'h81, 1'b1, 1'b0, 8'h00);
        frame_finish();

        // tx_load collisions: ignored while pending, accepted on the consume cycle
        host_load(8'h11);
        host_load(8'h22);
        bus.csn = 1'b0;
        m_starts++;
        model_boundary();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_start) seen = 1'b1;
        end
        chk("frame_start_seen", {31'd0, seen}, 1);
        bus.tx_byte = 8'h33;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
        host_load_model: begin
            m_hold    = 8'h33;
            m_pending = 1'b1;
        end
        step(HALF);
        chk("tx_pending_after_consume_load", {31'd0, bus.tx_pending}, 1);
        spi_byte(8'hC3, 1'b0, 1'b0, 8'h00);
        spi_byte(8'h3A, 1'b1, 1'b0, 8'h00);
        frame_finish();

        // Reset in the middle of a byte
        host_load(8'h77);
        frame_begin();
        void'(exp_tx.pop_front());
        for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, r);
        rst = 1'b1;
        step(2);
        chk_reset_vals("midrst");
        rst = 1'b0;
        m_pending = 1'b0;
        for (int i = 0; i < 5; i++) begin
            spi_bit(1'b1, i == 4, r);
            chk("miso_oe_after_rst", {31'd0, bus.miso_oe}, 0);
        end
        frame_finish();
        frame_begin();
        spi_byte(8'h5A, 1'b1, 1'b0, 8'h00);
        frame_finish();

        // SCLK activity with CSN high
        for (int i = 0; i < 6; i++) begin
            bus.sclk = 1'b1;
            step(HALF);
            chk("glitch_miso_oe", {31'd0, bus.miso_oe}, 0);
            bus.sclk = 1'b0;
            step(HALF);
            chk("glitch_busy", {31'd0, bus.busy}, 0);
        end
        frame_finish();

        // Randomized frames against the reference model
        for (int f = 0; f < 15; f++) begin
            nb = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) host_load(8'($urandom));
            frame_begin();
            for (int b = 0; b < nb; b++) begin
                spi_byte(8'($urandom), b == nb - 1, $urandom_range(0, 1) == 1, 8'($urandom));
            end
            frame_finish();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
